seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a multi-digit common-anode seven-segment display that shares one BCD-to-segment decoder between all digits. The block keeps a committed copy of the digit values and steps through the digits in turn. For each digit it drives the 4-bit code onto the shared decoder input `cntr` and asserts that digit's active-low anode. New digit values arrive through a valid/ready handshake and take effect only at a frame boundary, so the display never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, default 4: number of digits; range 2..8.
- `DIGIT_CYC`, default 50000: clock cycles each digit is lit (SHOW phase); must be ≥1.
- `GUARD_CYC`, default 16: all-dark cycles before each digit (GUARD phase, anti-ghosting); must be ≥1.

- `clk` in 1: the single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: scanning enable.
- `upd_valid` in 1: a new digit set is offered.
- `upd_data` in 4*NUM_DIGITS: BCD digits; `[3:0]` is digit 0, the rightmost.
- `upd_ready` out 1: high when an offered update can be accepted.
- `upd_done` out 1: one-cycle pulse on the cycle a pending update is committed.
- `cntr` out 4: code sent to the shared decoder; 4'hF means blank.
- `anode` out NUM_DIGITS: active-low digit enables; at most one bit low at any time.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - `state` ∈ {GUARD, SHOW}.
  - Phase counter `pcnt`, width `$clog2(max(DIGIT_CYC,GUARD_CYC))`.
  - Digit index `idx`, width `$clog2(NUM_DIGITS)`.
  - `shadow` and `disp`, each 4*NUM_DIGITS.
  - `pending` flag.
- GUARD:
  - `anode` all ones, `cntr` = 4'hF.
  - After GUARD_CYC cycles, go to SHOW with `pcnt` = 0.
- SHOW:
  - `anode[idx]` = 0, `cntr` = `disp[4*idx +: 4]`.
  - After DIGIT_CYC cycles, go to GUARD with `pcnt` = 0.
  - `idx` advances modulo NUM_DIGITS.
- Frame boundary: the SHOW→GUARD transition where `idx` wraps from NUM_DIGITS-1 to 0.
  - `frame_tick` pulses on that cycle.
  - If `pending`, then `disp` ← `shadow`, `pending` ← 0, and `upd_done` pulses in the same cycle.
- Handshake:
  - `upd_ready` = !`pending`.
  - An update is accepted on any cycle where `upd_valid` && `upd_ready`: `shadow` ← `upd_data`, `pending` ← 1.
  - While `pending` is set, further offers stall; the source holds `upd_valid` and `upd_data` until ready.
  - Accept and commit never happen in the same cycle, because accept requires !`pending` and commit requires `pending`.
- `enable` = 0:
  - Next state is GUARD with `pcnt` = 0 and `idx` = 0; outputs dark.
  - A pending update commits on the next cycle (`upd_done` pulses); `frame_tick` stays 0.
  - When `enable` returns to 1, scanning restarts with a fresh GUARD for digit 0.
- Codes 4'hA–4'hF in `disp` pass through unchanged. The decoder shows them as blank.

## Timing
- Reset values:
  - `state` = GUARD; `pcnt` = 0; `idx` = 0; `pending` = 0.
  - `disp` and `shadow` all 4'hF.
  - `anode` all ones, `cntr` = 4'hF.
  - `upd_ready` = 1, `upd_done` = 0, `frame_tick` = 0.
- `rst` overrides `enable`. Reset mid-frame or with an update pending discards the pending update; no `upd_done` pulse.
- All outputs are registered and change on the same edge as `state`/`idx`. Combinational cone to `cntr`/`anode`: none.
- Digit period = GUARD_CYC + DIGIT_CYC. Frame period = NUM_DIGITS × (GUARD_CYC + DIGIT_CYC).
- Update latency: a value accepted at cycle t appears on `cntr` at the first digit-0 SHOW after the next frame boundary. Worst case ≈ one frame + GUARD_CYC.
- `upd_ready` falls the cycle after acceptance. It rises the cycle after `upd_done`.

## Configuration
- `SEG_LZB_EN` (leading-zero blanking) defined:
  - During SHOW, digit i > 0 drives `cntr` = 4'hF when `disp` digits i..NUM_DIGITS-1 are all 4'h0.
  - Digit 0 always shows its value.
  - The blanking decision is registered with the other outputs; latency is unchanged.
- `SEG_LZB_EN` undefined: every digit shows its `disp` value, including leading zeros.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, DIGIT_CYC=4, GUARD_CYC=1 (frame = 20 cycles).
- Reset then idle scan, `enable`=1: `anode` cycles 1111, 1110×4, 1111, 1101×4, …. `cntr`=4'hF throughout. `frame_tick` pulses every 20 cycles.
- Offer `upd_data`=16'h1234 mid-frame: `upd_ready` drops the next cycle. At the frame boundary `upd_done` pulses. Next frame: `cntr` = 4, 3, 2, 1 with `anode` = 1110, 1101, 1011, 0111.
- Second offer 16'h5678 held while pending: it is not accepted until the cycle after `upd_done`. The display never mixes digits of 1234 and 5678 within one frame.
- `enable` dropped mid-SHOW of digit 2 with an update pending: the next cycle `anode`=1111 and `upd_done` pulses. On re-enable, scanning restarts with GUARD, then digit 0 shows the new value.
- `rst` asserted mid-frame with 16'h9999 pending: all reset values appear the next cycle, no `upd_done`, `disp` = all 4'hF.
- With `SEG_LZB_EN`, `disp`=16'h0070: digits 3 and 2 show `cntr`=4'hF, digit 1 shows 7, digit 0 shows 0. Without `SEG_LZB_EN`: 0, 0, 7, 0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scanner with a frame-aligned digit update path.
// Optional leading-zero blanking is built when the SEG_LZB_EN macro is defined.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_CYC  = 50000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ready,
    output logic                    upd_done,
    output logic [3:0]              cntr,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick,
    output logic                    dbg_state
);

    localparam int MAX_CYC = (DIGIT_CYC > GUARD_CYC) ? DIGIT_CYC : GUARD_CYC;
    localparam int PCNT_W  = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [PCNT_W-1:0] GUARD_LAST = PCNT_W'(GUARD_CYC - 1);
    localparam logic [PCNT_W-1:0] DIGIT_LAST = PCNT_W'(DIGIT_CYC - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [PCNT_W-1:0]       pcnt_q, pcnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DW-1:0]           shadow_q, shadow_d;
    logic [DW-1:0]           disp_q, disp_d;
    logic                    pending_q, pending_d;
    logic                    upd_ready_q, upd_ready_d;
    logic                    upd_done_q, upd_done_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [3:0]              cntr_q, cntr_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;

    logic                    boundary;
    logic                    commit;
    logic                    accept;
`ifdef SEG_LZB_EN
    logic [NUM_DIGITS-1:0]   lead_zero;
`endif

    // Scan sequencer: GUARD (dark) then SHOW for each digit; disable parks it at GUARD of digit 0.
    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        idx_d    = idx_q;
        boundary = 1'b0;
        if (!enable) begin
            state_d = ST_GUARD;
            pcnt_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_GUARD: begin
                    if (pcnt_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (pcnt_q == DIGIT_LAST) begin
                        state_d = ST_GUARD;
                        pcnt_d  = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_GUARD;
                    pcnt_d  = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Handshake: a transfer happens on a cycle with upd_valid && upd_ready; the source holds
    // valid and data stable until then. Ready stays low while an update waits for a frame
    // boundary and for the cycle that reports its commit, so accept and commit never overlap.
    always_comb begin
        accept      = upd_valid && upd_ready_q;
        commit      = pending_q && (boundary || !enable);
        shadow_d    = accept ? upd_data : shadow_q;
        disp_d      = commit ? shadow_q : disp_q;
        pending_d   = accept ? 1'b1 : (commit ? 1'b0 : pending_q);
        upd_ready_d = !pending_d && !commit;
        upd_done_d  = commit;
        frame_tick_d = boundary;
    end

`ifdef SEG_LZB_EN
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (disp_d[DW-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (disp_d[4*i +: 4] == 4'h0);
        end
    end
`endif

    // Outputs are computed from the next-state values so they flip on the same edge as state/idx.
    always_comb begin
        anode_d = '1;
        cntr_d  = 4'hF;
        if (state_d == ST_SHOW) begin
            anode_d[idx_d] = 1'b0;
            cntr_d         = disp_d[4*idx_d +: 4];
`ifdef SEG_LZB_EN
            if ((idx_d != '0) && lead_zero[idx_d]) begin
                cntr_d = 4'hF;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GUARD;
            pcnt_q       <= '0;
            idx_q        <= '0;
            shadow_q     <= '1;
            disp_q       <= '1;
            pending_q    <= 1'b0;
            upd_ready_q  <= 1'b1;
            upd_done_q   <= 1'b0;
            frame_tick_q <= 1'b0;
            cntr_q       <= 4'hF;
            anode_q      <= '1;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            upd_ready_q  <= upd_ready_d;
            upd_done_q   <= upd_done_d;
            frame_tick_q <= frame_tick_d;
            cntr_q       <= cntr_d;
            anode_q      <= anode_d;
        end
    end

    assign upd_ready  = upd_ready_q;
    assign upd_done   = upd_done_q;
    assign frame_tick = frame_tick_q;
    assign cntr       = cntr_q;
    assign anode      = anode_q;
    assign dbg_state  = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomized and directed bench for seven_seg_scanner against a time-slot reference model.
module tb_seven_seg_scanner;

    localparam int N     = 4;
    localparam int DC    = 4;
    localparam int GC    = 1;
    localparam int DP    = DC + GC;
    localparam int FRAME = N * DP;
    localparam int EW    = N + 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           upd_valid;
    logic [4*N-1:0] upd_data;
    logic           upd_ready;
    logic           upd_done;
    logic [3:0]     cntr;
    logic [N-1:0]   anode;
    logic           frame_tick;
    logic           dbg_state;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(N),
        .DIGIT_CYC (DC),
        .GUARD_CYC (GC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .upd_ready (upd_ready),
        .upd_done  (upd_done),
        .cntr      (cntr),
        .anode     (anode),
        .frame_tick(frame_tick),
        .dbg_state (dbg_state)
    );

    // Reference model: position in the frame is derived from cycles since scanning (re)started.
    int          t;
    logic [3:0]  m_disp[N];
    logic [3:0]  m_shadow[N];
    bit          m_pending, m_ready, m_done, m_tick, m_accepted;
    logic [EW-1:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    endtask

    function automatic logic [EW-1:0] expected_outputs();
        int slot, dig;
        bit lit, blank;
        logic [N-1:0] a;
        logic [3:0]   c;
        slot  = t % FRAME;
        dig   = slot / DP;
        lit   = (slot % DP) >= GC;
        a     = '1;
        c     = 4'hF;
        blank = 1'b0;
`ifdef SEG_LZB_EN
        if (dig > 0) begin
            blank = 1'b1;
            for (int k = dig; k < N; k++) if (m_disp[k] != 4'h0) blank = 1'b0;
        end
`endif
        if (lit) begin
            a[dig] = 1'b0;
            c      = blank ? 4'hF : m_disp[dig];
        end
        return {a, c, m_tick, m_done, m_ready};
    endfunction

    task automatic model_edge();
        bit boundary, commit, accept;
        if (rst) begin
            t = 0;
            for (int i = 0; i < N; i++) begin
                m_disp[i]   = 4'hF;
                m_shadow[i] = 4'hF;
            end
            m_pending  = 0;
            m_ready    = 1;
            m_done     = 0;
            m_tick     = 0;
            m_accepted = 0;
        end else begin
            accept = upd_valid && m_ready;
            if (enable) t++;
            else t = 0;
            boundary = enable && (t % FRAME == 0);
            commit   = m_pending && (boundary || !enable);
            if (commit) for (int i = 0; i < N; i++) m_disp[i] = m_shadow[i];
            if (accept) for (int i = 0; i < N; i++) m_shadow[i] = upd_data[4*i +: 4];
            if (accept) m_pending = 1;
            else if (commit) m_pending = 0;
            m_done     = commit;
            m_tick     = boundary;
            m_ready    = !m_pending && !commit;
            m_accepted = accept;
        end
        exp_q.push_back(expected_outputs());
    endtask

    task automatic compare();
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("anode",      32'(anode),      32'(e[EW-1 -: N]));
        check("cntr",       32'(cntr),       32'(e[6:3]));
        check("frame_tick", 32'(frame_tick), 32'(e[2]));
        check("upd_done",   32'(upd_done),   32'(e[1]));
        check("upd_ready",  32'(upd_ready),  32'(e[0]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        if (m_accepted) upd_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic offer(input logic [4*N-1:0] v);
        upd_valid = 1'b1;
        upd_data  = v;
    endtask

    task automatic wait_accept();
        bit got;
        got = 0;
        for (int i = 0; i < 2 * FRAME + 5 && !got; i++) begin
            step();
            got = m_accepted;
        end
        check("accept_timeout", 32'(got), 32'd1);
    endtask

    function automatic logic [4*N-1:0] rand_digits();
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++)
            v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        run(2);
        rst    = 1'b0;
        enable = 1'b1;

        // Idle scan with blank digits.
        run(45);

        // Update mid-frame, then a second offer held while the first is pending.
        run(7);
        offer(16'h1234);
        wait_accept();
        offer(16'h5678);
        run(70);

        // Disable during SHOW of digit 2 with an update pending.
        offer(16'h4321);
        wait_accept();
        for (int i = 0; i < FRAME && (t % FRAME) != 2 * DP + GC + 1; i++) step();
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(25);

        // Reset with an update pending.
        offer(16'h9999);
        wait_accept();
        run(3);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(25);

        // Leading zeros.
        offer(16'h0070);
        wait_accept();
        run(45);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (!upd_valid && $urandom_range(0, 7) == 0) offer(rand_digits());
            enable = ($urandom_range(0, 19) != 0);
            rst    = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
